dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM for the MIPS load/store port,
// sitting behind a valid/ready request/response handshake. One transaction
// is in flight at a time, and WAIT_STATES cycles are inserted before the
// array access. Stores use per-byte enables.
// Optional feature: define DMEM_RANGE_CHECK_EN to reject addresses whose
// upper bits are nonzero. Such a request gets rsp_err=1, no write, and
// rsp_rdata=0. Without the macro, upper address bits alias into the RAM.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [3:0]              wait_cnt;
  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              be_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   wr_word;
  logic                    accept;
  logic                    range_ok;
  logic                    mem_write;

  assign accept = req_valid && req_ready;

`ifdef DMEM_RANGE_CHECK_EN
  logic in_range_q;

  // Classify the request address as in or out of range when it is accepted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_range_q <= 1'b1;
    end else if (accept) begin
      in_range_q <= (req_addr[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
    end
  end

  assign range_ok = in_range_q;

  // Error flag is produced in ACCESS and held through RESP
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_err <= 1'b0;
    end else if (state == S_ACCESS) begin
      rsp_err <= !in_range_q;
    end
  end
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:DEPTH_LOG2];
  assign range_ok         = 1'b1;
  assign rsp_err          = 1'b0;
`endif

  // Write enable. It is gated by reset so that a store caught by reset is dropped
  assign mem_write = (state == S_ACCESS) && we_q && range_ok && reset;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the serialised transaction sequence
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (wait_cnt <= 4'd1) state_next = S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Handshake outputs. req_ready stays low while reset is asserted
  always_comb begin
    req_ready = (state == S_IDLE) && reset;
    rsp_valid = (state == S_RESP);
  end

  // Capture the request, count the wait states and load the response data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= 4'd0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      be_q      <= 4'd0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        wait_cnt <= WAIT_INIT;
        we_q     <= req_we;
        idx_q    <= req_addr[DEPTH_LOG2-1:0];
        wdata_q  <= req_wdata;
        be_q     <= req_be;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == S_ACCESS) begin
        rsp_rdata <= (we_q || !range_ok) ? '0 : mem[idx_q];
      end
    end
  end

  // Merge the enabled store bytes into the currently stored word
  always_comb begin
    wr_word = mem[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) wr_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // RAM array. Its contents are not cleared by reset
  always_ff @(posedge clock) begin
    if (mem_write) mem[idx_q] <= wr_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder.
// Instance 0 uses WAIT_STATES=2 and instance 1 uses WAIT_STATES=0.
// Range-check expectations follow DMEM_RANGE_CHECK_EN.
module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int errors;
  int checks;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(8), .WAIT_STATES(2)) dut_w2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(8), .WAIT_STATES(0)) dut_w0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit in case the design hangs the handshake
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // One full transaction: present request, measure edges to rsp_valid, then handshake
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clock);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be; rsp_ready[d] = 1'b0;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge clock); n++; end
    @(posedge clock);
    @(negedge clock);
    req_valid[d] = 1'b0;
    lat = 0;
    while (!rsp_valid[d] && lat < 50) begin
      @(posedge clock); lat++; @(negedge clock);
    end
    if (!rsp_valid[d]) lat = 99;
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
    end
    #3;
    checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_ready0: got %b expected 0", req_ready[0]); end
    checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_ready1: got %b expected 0", req_ready[1]); end
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_valid: got %b expected 0", rsp_valid[0]); end
    checks++; if (rsp_rdata[0] !== 32'h0) begin errors++; $display("[TB] FAIL rst_rsp_rdata: got %h expected 00000000", rsp_rdata[0]); end
    checks++; if (rsp_err[0] !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_err: got %b expected 0", rsp_err[0]); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL rel_req_ready0: got %b expected 1", req_ready[0]); end
    checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("[TB] FAIL rel_req_ready1: got %b expected 1", req_ready[1]); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h05, 32'hDEADBEEF, 4'b1111, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL store_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL store_rdata: got %h expected 00000000", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL store_err: got %b expected 0", er); end
    txn(0, 1'b0, 32'h05, 32'h0, 4'b0000, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL load_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_rdata: got %h expected deadbeef", rd); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h05, 32'h000000AA, 4'b0001, rd, er, lat);
    txn(0, 1'b0, 32'h05, 32'h0, 4'b1111, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("[TB] FAIL be0001: got %h expected deadbeaa", rd); end
    txn(0, 1'b1, 32'h05, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL be0000_latency: got %0d expected 3", lat); end
    txn(0, 1'b0, 32'h05, 32'h0, 4'b0000, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("[TB] FAIL be0000: got %h expected deadbeaa", rd); end
    txn(0, 1'b1, 32'h05, 32'h11223344, 4'b1010, rd, er, lat);
    txn(0, 1'b0, 32'h05, 32'h0, 4'b0000, rd, er, lat);
    checks++; if (rd !== 32'h11AD33AA) begin errors++; $display("[TB] FAIL be1010: got %h expected 11ad33aa", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n;
    @(negedge clock);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h05; rsp_ready[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_wdata[0] = 32'h0; req_be[0] = 4'b1111;
    n = 0;
    while (!rsp_valid[0] && n < 50) begin @(negedge clock); n++; end
    for (int k = 0; k < 5; k++) begin
      checks++; if (rsp_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", k, rsp_valid[0]); end
      checks++; if (rsp_rdata[0] !== 32'h11AD33AA) begin errors++; $display("[TB] FAIL hold_rdata[%0d]: got %h expected 11ad33aa", k, rsp_rdata[0]); end
      checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("[TB] FAIL hold_req_ready[%0d]: got %b expected 0", k, req_ready[0]); end
      @(negedge clock);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b0;
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL post_hs_valid: got %b expected 0", rsp_valid[0]); end
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL post_hs_req_ready: got %b expected 1", req_ready[0]); end
    txn(0, 1'b0, 32'h05, 32'h0, 4'b0000, rd, er, lat);
    checks++; if (rd !== 32'h11AD33AA) begin errors++; $display("[TB] FAIL ignored_store: got %h expected 11ad33aa", rd); end
  endtask

  task automatic test_back_to_back();
    int first; int second;
    first = -1; second = -1;
    @(negedge clock);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h05; rsp_ready[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (req_ready[0]) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      @(negedge clock);
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b0;
    checks++; if (first !== 0) begin errors++; $display("[TB] FAIL b2b_first: got %0d expected 0", first); end
    checks++; if (second - first !== 5) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 5", second - first); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic er; int lat;
    txn(1, 1'b1, 32'hFF, 32'hCAFEF00D, 4'b1111, rd, er, lat);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL w0_store_latency: got %0d expected 1", lat); end
    txn(1, 1'b0, 32'hFF, 32'h0, 4'b0000, rd, er, lat);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL w0_load_latency: got %0d expected 1", lat); end
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL w0_load_rdata: got %h expected cafef00d", rd); end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_rd0; logic exp_er; logic [31:0] exp_rd_hi;
`ifdef DMEM_RANGE_CHECK_EN
    exp_er = 1'b1; exp_rd0 = 32'h0BADF00D; exp_rd_hi = 32'h0;
`else
    exp_er = 1'b0; exp_rd0 = 32'h55555555; exp_rd_hi = 32'h55555555;
`endif
    txn(0, 1'b1, 32'h000, 32'h0BADF00D, 4'b1111, rd, er, lat);
    txn(0, 1'b1, 32'h100, 32'h55555555, 4'b1111, rd, er, lat);
    checks++; if (er !== exp_er) begin errors++; $display("[TB] FAIL range_store_err: got %b expected %b", er, exp_er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL range_store_rdata: got %h expected 00000000", rd); end
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL range_store_latency: got %0d expected 3", lat); end
    txn(0, 1'b0, 32'h000, 32'h0, 4'b0000, rd, er, lat);
    checks++; if (rd !== exp_rd0) begin errors++; $display("[TB] FAIL range_load0: got %h expected %h", rd, exp_rd0); end
    checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL range_load0_err: got %b expected 0", er); end
    txn(0, 1'b0, 32'h100, 32'h0, 4'b0000, rd, er, lat);
    checks++; if (rd !== exp_rd_hi) begin errors++; $display("[TB] FAIL range_load_hi: got %h expected %h", rd, exp_rd_hi); end
    checks++; if (er !== exp_er) begin errors++; $display("[TB] FAIL range_load_hi_err: got %b expected %b", er, exp_er); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h10, 32'h12345678, 4'b1111, rd, er, lat);
    @(negedge clock);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10;
    req_wdata[0] = 32'hFFFFFFFF; req_be[0] = 4'b1111; rsp_ready[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", rsp_valid[0]); end
    checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_req_ready: got %b expected 0", req_ready[0]); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL mid_rel_req_ready: got %b expected 1", req_ready[0]); end
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL mid_rel_valid: got %b expected 0", rsp_valid[0]); end
    txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("[TB] FAIL mid_rst_dropped_store: got %h expected 12345678", rd); end
  endtask

  // Run all scenarios in order, then print the summary
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_backpressure();
    test_back_to_back();
    test_zero_wait();
    test_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
